// File: rtl/sram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// sram_rd_arbiter
//
// Shares one SRAM read port between NUM_REQ requesters using round-robin
// arbitration. Every read issued to the SRAM is tagged with the one-hot ID of
// its requester. The tag travels through an RD_LATENCY-deep pipeline, so the
// returning data is steered back to the requester that issued the read.
//
// Optional feature (macro SRAM_RD_ARB_LOCK_EN):
//   When the macro is defined, a requester can hold the grant for consecutive
//   beats with ReqLock. A lock lasts at most MAX_LOCK beats. When the macro is
//   undefined, ReqLock is ignored and the block is pure round-robin.
//
// Ports:
//   Clk         in   rising-edge clock
//   Rst         in   synchronous active-high reset
//   ReqValid    in   [NUM_REQ]             per-requester read request
//   ReqAddr     in   [NUM_REQ*ADDR_WIDTH]  packed addresses, requester i at
//                                          [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ReqLock     in   [NUM_REQ]             keep the grant for the next beat
//   ReqReady    out  [NUM_REQ]             one-hot grant (combinational)
//   RspValid    out  [NUM_REQ]             one-hot response valid
//   RspData     out  [DATA_WIDTH]          read data, broadcast to everyone
//   SramRdAddr  out  [ADDR_WIDTH]          SRAM read address (0 when idle)
//   SramRdEn    out                        SRAM read enable
//   SramRdData  in   [DATA_WIDTH]          SRAM read data
// -----------------------------------------------------------------------------
module sram_rd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1,
   parameter int MAX_LOCK   = 16
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [NUM_REQ-1:0]            ReqValid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr,
   input  logic [NUM_REQ-1:0]            ReqLock,
   output logic [NUM_REQ-1:0]            ReqReady,
   output logic [NUM_REQ-1:0]            RspValid,
   output logic [DATA_WIDTH-1:0]         RspData,
   output logic [ADDR_WIDTH-1:0]         SramRdAddr,
   output logic                          SramRdEn,
   input  logic [DATA_WIDTH-1:0]         SramRdData
);

   localparam int PTR_W = $clog2(NUM_REQ);

   // Next requester index after idx, wrapping at NUM_REQ.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      logic [PTR_W-1:0] nxt;
      if (int'(idx) == NUM_REQ - 1) nxt = '0;
      else                          nxt = idx + PTR_W'(1);
      return nxt;
   endfunction

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic               gnt_valid;
   logic [PTR_W-1:0]   gnt_idx;
   // Each stage is a one-hot ID; a stage is valid when any bit is set.
   logic [NUM_REQ-1:0] tag_q [RD_LATENCY];
   logic [NUM_REQ-1:0] tag_d [RD_LATENCY];

`ifdef SRAM_RD_ARB_LOCK_EN
   localparam int CNT_W = $clog2(MAX_LOCK);

   typedef enum logic {
      ARB,
      LOCKED
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
   // Lock feature absent: ReqLock and MAX_LOCK are intentionally unused.
   localparam int unused_max_lock = MAX_LOCK;
   logic unused_lock;
   assign unused_lock = ^ReqLock;
`endif

   // --------------------------------------------------------------------------
   // Round-robin search: first valid request at or after ptr_q, wrapping.
   // --------------------------------------------------------------------------
   always_comb begin
      logic [PTR_W-1:0] cand;
      // NOTE: every variable gets a default at the top of an always_comb so no
      // path leaves it unassigned, which would otherwise infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!win_found && ReqValid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Grant selection. While locked only the owner may be granted; the grant is
   // suppressed entirely while reset is high.
   // --------------------------------------------------------------------------
   always_comb begin
      gnt_valid = win_found;
      gnt_idx   = win_idx;
`ifdef SRAM_RD_ARB_LOCK_EN
      if (state_q == LOCKED) begin
         gnt_valid = ReqValid[owner_q];
         gnt_idx   = owner_q;
      end
`endif
      if (Rst) gnt_valid = 1'b0;
   end

   // One-hot grant and SRAM address mux; address is 0 when idle.
   always_comb begin
      ReqReady   = '0;
      SramRdAddr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_valid && (gnt_idx == PTR_W'(i))) begin
            ReqReady[i] = 1'b1;
            SramRdAddr  = ReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign SramRdEn = gnt_valid;

   // --------------------------------------------------------------------------
   // Pointer and lock state next-state logic.
   // --------------------------------------------------------------------------
`ifdef SRAM_RD_ARB_LOCK_EN
   always_comb begin
      ptr_d      = ptr_q;
      state_d    = state_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         ARB: begin
            if (gnt_valid) begin
               ptr_d = wrap_inc(gnt_idx);
               if (ReqLock[gnt_idx]) begin
                  state_d    = LOCKED;
                  owner_d    = gnt_idx;
                  lock_cnt_d = CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            // Any owner transfer or release points past the owner so waiting
            // requesters are searched first once the lock ends.
            ptr_d = wrap_inc(owner_q);
            if (gnt_valid) begin
               if (!ReqLock[owner_q] || (lock_cnt_q == CNT_W'(MAX_LOCK - 1))) begin
                  state_d    = ARB;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end
            end else begin
               // Owner dropped its request: release without a transfer.
               state_d    = ARB;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ARB;
            lock_cnt_d = '0;
         end
      endcase
   end
`else
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_valid) ptr_d = wrap_inc(gnt_idx);
   end
`endif

   // --------------------------------------------------------------------------
   // Tag pipeline: stage 0 captures the grant, later stages shift.
   // --------------------------------------------------------------------------
   always_comb begin
      tag_d[0] = ReqReady;
      for (int s = 1; s < RD_LATENCY; s++) begin
         tag_d[s] = tag_q[s-1];
      end
   end

   assign RspValid = tag_q[RD_LATENCY-1];
   assign RspData  = SramRdData;

   // --------------------------------------------------------------------------
   // State registers.
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ptr_q <= '0;
         // NOTE: the tag stages are cleared on reset, unlike a data RAM, because
         // a stale tag would raise RspValid for a read nobody is waiting for.
         for (int s = 0; s < RD_LATENCY; s++) begin
            tag_q[s] <= '0;
         end
`ifdef SRAM_RD_ARB_LOCK_EN
         state_q    <= ARB;
         owner_q    <= '0;
         lock_cnt_q <= '0;
`endif
      end else begin
         ptr_q <= ptr_d;
         for (int s = 0; s < RD_LATENCY; s++) begin
            tag_q[s] <= tag_d[s];
         end
`ifdef SRAM_RD_ARB_LOCK_EN
         state_q    <= state_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

endmodule
